// File: rtl/audio_serializer_if.sv
// Sample handshake between the audio_output stage (master) and the serializer FIFO (slave).
interface audio_serializer_if;
    logic [31:0] audio;
    logic        audio_valid;
    logic        audio_ready;

    modport master (
        output audio,
        output audio_valid,
        input  audio_ready
    );

    modport slave (
        input  audio,
        input  audio_valid,
        output audio_ready
    );
endinterface

// File: rtl/audio_serializer.sv
// Mono PCM sample FIFO feeding a 64-bit-frame I2S transmitter (sample duplicated in both slots).
// Define AUDIO_SERIALIZER_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module audio_serializer #(
    parameter int CLKDIV     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    audio_serializer_if.slave aud,
    input  logic              enable,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_sdata,
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_count,
`endif
    output logic              underrun
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0]       DIV_MAX = 8'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MIN_RUN = CNT_W'(2);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    state_t           state_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ready_en_q;
    logic [7:0]       div_q;
    logic [5:0]       bit_q;
    logic [5:0]       bit_d;
    logic [31:0]      frame_q;
    logic             bclk_q;
    logic             lrck_q;
    logic             sdata_q;
    logic             sdata_d;
    logic             underrun_q;
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
    logic [15:0]      ur_cnt_q;
`endif

    logic push;
    logic pop;
    logic bclk_tick;
    logic bclk_fall;
    logic frame_wrap;
    logic frame_start;

    // ready_en_q keeps ready low during reset even though the empty count would allow a push
    assign aud.audio_ready = ready_en_q && (count_q != FULL);
    assign push            = aud.audio_valid && aud.audio_ready;

    assign bclk_tick   = (state_q != ST_IDLE) && (div_q == DIV_MAX);
    assign bclk_fall   = bclk_tick && bclk_q;
    assign frame_wrap  = bclk_fall && (bit_q == 6'd63);
    assign frame_start = ((state_q == ST_IDLE) && enable && (count_q >= MIN_RUN)) ||
                         ((state_q == ST_RUN) && frame_wrap);
    assign pop         = frame_start && (count_q != '0);
    assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    assign bit_d       = bit_q + 6'd1;
    // The slot being entered carries the frame bit of the slot just left (one-bit delay).
    assign sdata_d     = frame_q[5'd31 - bit_q[4:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= aud.audio;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b1;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
            ur_cnt_q   <= '0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            count_q    <= count_d;
            underrun_q <= frame_start && !pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (frame_start) begin
                frame_q <= pop ? fifo_mem[rd_ptr_q] : '0;
            end
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
            if (frame_start && !pop && (ur_cnt_q != 16'hFFFF)) begin
                ur_cnt_q <= ur_cnt_q + 16'd1;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    div_q   <= '0;
                    bit_q   <= '0;
                    bclk_q  <= 1'b0;
                    sdata_q <= 1'b0;
                    lrck_q  <= !frame_start;
                    if (frame_start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (bclk_tick) begin
                        div_q  <= '0;
                        bclk_q <= !bclk_q;
                        if (bclk_q) begin
                            bit_q   <= bit_d;
                            lrck_q  <= bit_d[5];
                            sdata_q <= sdata_d;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                    if ((state_q == ST_RUN) && !enable) begin
                        state_q <= ST_DRAIN;
                    end
                    // The last falling edge of a draining frame lands directly on idle levels.
                    if ((state_q == ST_DRAIN) && frame_wrap) begin
                        state_q <= ST_IDLE;
                        lrck_q  <= 1'b1;
                        sdata_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrck  = lrck_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
    assign underrun_count = ur_cnt_q;
`endif
endmodule
